pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Central stall/flush controller for the 5-stage RISC-V pipeline. It generates the write-enable, hold and bubble controls for the PC and for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It sequences three events: multi-cycle data-memory accesses (req/ready handshake with timeout), load-use hazards, and taken-branch flushes. It also keeps a saturating stall-cycle counter and a sticky memory-error flag.

## Interface
Parameters:
- MAX_WAIT, 15: maximum consecutive frozen cycles per data-memory access before timeout (≥1).
- CNT_W, 32: width of the stall-cycle counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; one clock, one reset; sampled on posedge clk.
- IF_ID_rs1, IF_ID_rs2  in  5  source registers of the instruction in ID.
- ID_EX_rd  in  5  destination register of the instruction in EX.
- ID_EX_MemRead  in  1  instruction in EX is a load.
- EX_branch_taken  in  1  branch resolved taken in EX.
- EX_MEM_MemRead, EX_MEM_MemWrite  in  1  instruction in MEM accesses data memory.
- dmem_ready  in  1  data memory completes the access this cycle.
- dmem_req  out  1  data-memory request.
- PC_write  out  1  PC update enable.
- IF_ID_write  out  1  IF/ID load enable.
- IF_ID_flush  out  1  IF/ID clear to NOP.
- ID_EX_hold  out  1  ID/EX keeps its contents.
- ID_EX_bubble  out  1  ID/EX loads zero control bits.
- EX_MEM_hold  out  1  EX/MEM keeps its contents.
- MEM_WB_bubble  out  1  MEM/WB loads RegWrite=0, MemtoReg=0.
- mem_error  out  1  sticky timeout flag.
- stall_count  out  CNT_W  cycles lost to freeze or load-use stalls.

## Operation
- Registered state: FSM {RUN, MEM_WAIT}, wait_cnt (4+ bits, wide enough for MAX_WAIT), mem_error, stall_count. All other outputs are combinational from state and inputs (Mealy).
- Intermediate signals:
  - access = EX_MEM_MemRead | EX_MEM_MemWrite.
  - timeout = (state==MEM_WAIT) & (wait_cnt==MAX_WAIT) & !dmem_ready.
  - freeze = access & !dmem_ready & !timeout.
  - loaduse = ID_EX_MemRead & (ID_EX_rd!=0) & (ID_EX_rd==IF_ID_rs1 | ID_EX_rd==IF_ID_rs2).
- dmem_req = access, in either state.
- Controls, evaluated in priority order. Defaults are PC_write=1, IF_ID_write=1, all others 0.
  1. freeze: PC_write=0, IF_ID_write=0, ID_EX_hold=1, EX_MEM_hold=1, MEM_WB_bubble=1. Flush and bubble outputs stay 0, so a taken branch in EX is deferred because EX is held.
  2. timeout: MEM_WB_bubble=1, which drops the access result. The pipeline otherwise advances, and branch/load-use rules apply as in RUN.
  3. EX_branch_taken: IF_ID_flush=1, ID_EX_bubble=1. This suppresses loaduse because the ID instruction is squashed.
  4. loaduse: PC_write=0, IF_ID_write=0, ID_EX_bubble=1.
- FSM transitions:
  - RUN→MEM_WAIT on freeze, wait_cnt←1.
  - MEM_WAIT with dmem_ready→RUN, wait_cnt←0.
  - MEM_WAIT with freeze: stay, wait_cnt←wait_cnt+1.
  - MEM_WAIT with timeout→RUN, wait_cnt←0, mem_error←1.
- mem_error stays set until reset.
- stall_count increments on each cycle with freeze, or with loaduse that is not overridden by branch. It saturates at 2^CNT_W−1 and never wraps.

## Timing
- Reset values: state=RUN, wait_cnt=0, mem_error=0, stall_count=0.
- Combinational outputs with all inputs 0 during or after reset: PC_write=1, IF_ID_write=1, all other outputs 0.
- Reset asserted mid-MEM_WAIT returns the FSM to RUN at the next edge. It clears mem_error and stall_count.
- Zero-wait access (dmem_ready in the same cycle as access) causes no stall and no state change.
- Wait accesses:
  - An access completing after N wait cycles (N<MAX_WAIT) freezes exactly N cycles. Freeze is asserted in the cycles before dmem_ready; the pipeline advances in the ready cycle.
  - A never-ready access freezes exactly MAX_WAIT cycles, then spends one timeout cycle. mem_error is visible the cycle after timeout.
- loaduse costs exactly one bubble per hazard. It is not re-evaluated as a hazard the next cycle, because the load has moved to MEM.
- rd=x0 never triggers loaduse.

## Structure
- Package pipe_ctrl_pkg:
  - state enum {RUN, MEM_WAIT}.
  - REG_X0 constant (5'd0).
  - Default MAX_WAIT and CNT_W localparams.
- Sub-module load_use_detect: combinational comparator producing loaduse. Instantiated once.
- Everything else lives in pipeline_hazard_ctrl.

## Test plan
- Reset, then idle inputs → PC_write=1, IF_ID_write=1, all else 0, stall_count=0.
- ID_EX_MemRead=1, ID_EX_rd=5, IF_ID_rs2=5 for 1 cycle → PC_write=0, IF_ID_write=0, ID_EX_bubble=1 for 1 cycle, stall_count=1. Repeating with rd=0 → no stall.
- Same load-use pattern plus EX_branch_taken=1 → IF_ID_flush=1, ID_EX_bubble=1, PC_write=1, stall_count unchanged.
- EX_MEM_MemRead=1, dmem_ready rises on the 4th cycle → freeze for 3 cycles, state MEM_WAIT, return to RUN, stall_count=3, mem_error=0.
- EX_MEM_MemWrite=1, dmem_ready never asserted, MAX_WAIT=15 → 15 frozen cycles, then 1 timeout cycle with MEM_WB_bubble=1 and PC_write=1, mem_error=1 next cycle and sticky. A following reset clears it.
- CNT_W=4, 20 load-use stalls → stall_count saturates at 15.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [4:0] REG_X0       = 5'd0;
    localparam int         DEF_MAX_WAIT = 15;
    localparam int         DEF_CNT_W    = 32;

    // Wait counter must hold MAX_WAIT itself and is never narrower than 4 bits.
    function automatic int wait_width(input int max_wait);
        int w;
        w = $clog2(max_wait + 1);
        return (w < 4) ? 4 : w;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Flags a load in EX whose destination feeds an operand of the instruction in ID.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] if_id_rs1,
    input  logic [4:0] if_id_rs2,
    input  logic [4:0] id_ex_rd,
    input  logic       id_ex_mem_read,
    output logic       loaduse
);

    assign loaduse = id_ex_mem_read && (id_ex_rd != REG_X0) &&
                     ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller: memory-wait freeze with timeout, load-use bubbles,
// branch flushes, a saturating stall counter and a sticky memory-error flag.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = DEF_MAX_WAIT,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       IF_ID_rs1,
    input  logic [4:0]       IF_ID_rs2,
    input  logic [4:0]       ID_EX_rd,
    input  logic             ID_EX_MemRead,
    input  logic             EX_branch_taken,
    input  logic             EX_MEM_MemRead,
    input  logic             EX_MEM_MemWrite,
    input  logic             dmem_ready,
    output logic             dmem_req,
    output logic             PC_write,
    output logic             IF_ID_write,
    output logic             IF_ID_flush,
    output logic             ID_EX_hold,
    output logic             ID_EX_bubble,
    output logic             EX_MEM_hold,
    output logic             MEM_WB_bubble,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_count
);

    localparam int WAIT_W = wait_width(MAX_WAIT);

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_error_q, mem_error_d;
    logic [CNT_W-1:0]  stall_count_q, stall_count_d;

    logic access, timeout, freeze, loaduse, stall_inc;

    load_use_detect u_load_use_detect (
        .if_id_rs1      (IF_ID_rs1),
        .if_id_rs2      (IF_ID_rs2),
        .id_ex_rd       (ID_EX_rd),
        .id_ex_mem_read (ID_EX_MemRead),
        .loaduse        (loaduse)
    );

    assign access    = EX_MEM_MemRead | EX_MEM_MemWrite;
    assign timeout   = (state_q == MEM_WAIT) && (wait_cnt_q == WAIT_W'(MAX_WAIT)) && !dmem_ready;
    assign freeze    = access && !dmem_ready && !timeout;
    assign stall_inc = freeze || (loaduse && !EX_branch_taken);

    assign dmem_req    = access;
    assign mem_error   = mem_error_q;
    assign stall_count = stall_count_q;

    // Freeze wins outright; a timeout only drops the result and lets branch/load-use act.
    always_comb begin
        PC_write      = 1'b1;
        IF_ID_write   = 1'b1;
        IF_ID_flush   = 1'b0;
        ID_EX_hold    = 1'b0;
        ID_EX_bubble  = 1'b0;
        EX_MEM_hold   = 1'b0;
        MEM_WB_bubble = 1'b0;
        if (freeze) begin
            PC_write      = 1'b0;
            IF_ID_write   = 1'b0;
            ID_EX_hold    = 1'b1;
            EX_MEM_hold   = 1'b1;
            MEM_WB_bubble = 1'b1;
        end else begin
            if (timeout) begin
                MEM_WB_bubble = 1'b1;
            end
            if (EX_branch_taken) begin
                IF_ID_flush  = 1'b1;
                ID_EX_bubble = 1'b1;
            end else if (loaduse) begin
                PC_write     = 1'b0;
                IF_ID_write  = 1'b0;
                ID_EX_bubble = 1'b1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_error_d   = mem_error_q | timeout;
        stall_count_d = stall_count_q;
        case (state_q)
            RUN: begin
                if (freeze) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end
            end
            MEM_WAIT: begin
                // Ready, timeout or an abandoned access all end the wait.
                if (freeze) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end else begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
        if (stall_inc && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RUN;
            wait_cnt_q    <= '0;
            mem_error_q   <= 1'b0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_error_q   <= mem_error_d;
            stall_count_q <= stall_count_d;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: two controller instances (default and small MAX_WAIT/CNT_W)
// checked each cycle against a consecutive-freeze-count reference model.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs1, rs2, rd;
    logic       id_mr, br, mr, mw, rdy;

    logic        req_a, pcw_a, ifw_a, fl_a, hold_a, bub_a, exh_a, wbb_a, err_a;
    logic [31:0] cnt_a;
    logic        req_b, pcw_b, ifw_b, fl_b, hold_b, bub_b, exh_b, wbb_b, err_b;
    logic [3:0]  cnt_b;

    localparam int MW_A = 15;
    localparam int MW_B = 3;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MAX_WAIT(MW_A), .CNT_W(32)) dut_a (
        .clk(clk), .reset(reset), .IF_ID_rs1(rs1), .IF_ID_rs2(rs2), .ID_EX_rd(rd),
        .ID_EX_MemRead(id_mr), .EX_branch_taken(br), .EX_MEM_MemRead(mr),
        .EX_MEM_MemWrite(mw), .dmem_ready(rdy), .dmem_req(req_a), .PC_write(pcw_a),
        .IF_ID_write(ifw_a), .IF_ID_flush(fl_a), .ID_EX_hold(hold_a),
        .ID_EX_bubble(bub_a), .EX_MEM_hold(exh_a), .MEM_WB_bubble(wbb_a),
        .mem_error(err_a), .stall_count(cnt_a)
    );

    pipeline_hazard_ctrl #(.MAX_WAIT(MW_B), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .IF_ID_rs1(rs1), .IF_ID_rs2(rs2), .ID_EX_rd(rd),
        .ID_EX_MemRead(id_mr), .EX_branch_taken(br), .EX_MEM_MemRead(mr),
        .EX_MEM_MemWrite(mw), .dmem_ready(rdy), .dmem_req(req_b), .PC_write(pcw_b),
        .IF_ID_write(ifw_b), .IF_ID_flush(fl_b), .ID_EX_hold(hold_b),
        .ID_EX_bubble(bub_b), .EX_MEM_hold(exh_b), .MEM_WB_bubble(wbb_b),
        .mem_error(err_b), .stall_count(cnt_b)
    );

    typedef struct {
        int          id;
        logic [7:0]  ctl_a;
        logic        err_a;
        longint      cnt_a;
        logic [7:0]  ctl_b;
        logic        err_b;
        longint      cnt_b;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;
    int   txn_id = 0;

    // Model state: frozen cycles already spent on the current access.
    int     k_a = 0, k_b = 0;
    bit     e_a = 0, e_b = 0;
    longint c_a = 0, c_b = 0;

    task automatic model_cycle(input int maxw, input longint cmax,
                               inout int k, inout bit err, inout longint cnt,
                               output logic [7:0] ctl, output logic err_o,
                               output longint cnt_o);
        bit acc, lu, tmo, frz;
        bit pc, ifw, fl, hold, bub, exh, wbb;
        acc = mr || mw;
        lu  = id_mr && (rd != 0) && (rd == rs1 || rd == rs2);
        tmo = (k == maxw) && !rdy;
        frz = acc && !rdy && !tmo;
        pc = 1; ifw = 1; fl = 0; hold = 0; bub = 0; exh = 0; wbb = 0;
        if (frz) begin
            pc = 0; ifw = 0; hold = 1; exh = 1; wbb = 1;
        end else begin
            if (tmo) wbb = 1;
            if (br) begin
                fl = 1; bub = 1;
            end else if (lu) begin
                pc = 0; ifw = 0; bub = 1;
            end
        end
        ctl   = {acc, pc, ifw, fl, hold, bub, exh, wbb};
        err_o = err;
        cnt_o = cnt;
        if (reset) begin
            k = 0; err = 0; cnt = 0;
        end else begin
            if (tmo) err = 1;
            k = frz ? k + 1 : 0;
            if ((frz || (lu && !br)) && cnt < cmax) cnt = cnt + 1;
        end
    endtask

    task automatic drive(input bit r, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [4:0] d, input bit idm, input bit b,
                         input bit m_r, input bit m_w, input bit rd_y);
        exp_t e;
        @(posedge clk);
        #1;
        reset = r; rs1 = s1; rs2 = s2; rd = d; id_mr = idm; br = b;
        mr = m_r; mw = m_w; rdy = rd_y;
        e.id = txn_id;
        txn_id++;
        model_cycle(MW_A, 64'hFFFF_FFFF, k_a, e_a, c_a, e.ctl_a, e.err_a, e.cnt_a);
        model_cycle(MW_B, 64'd15, k_b, e_b, c_b, e.ctl_b, e.err_b, e.cnt_b);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk(input string name, input int id, input longint act, input longint req);
        checks++;
        if (act == req) passed++;
        else $display("FAIL %s txn %0d: got %0h, expected %0h", name, id, act, req);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [7:0] ca, cb;
            e  = exp_q.pop_front();
            ca = {req_a, pcw_a, ifw_a, fl_a, hold_a, bub_a, exh_a, wbb_a};
            cb = {req_b, pcw_b, ifw_b, fl_b, hold_b, bub_b, exh_b, wbb_b};
            $display("txn %0d: ctl_a=%b err_a=%0d cnt_a=%0d ctl_b=%b err_b=%0d cnt_b=%0d",
                     e.id, ca, err_a, cnt_a, cb, err_b, cnt_b);
            chk("ctl_a", e.id, longint'(ca), longint'(e.ctl_a));
            chk("mem_error_a", e.id, longint'(err_a), longint'(e.err_a));
            chk("stall_count_a", e.id, longint'(cnt_a), e.cnt_a);
            chk("ctl_b", e.id, longint'(cb), longint'(e.ctl_b));
            chk("mem_error_b", e.id, longint'(err_b), longint'(e.err_b));
            chk("stall_count_b", e.id, longint'(cnt_b), e.cnt_b);
        end
    end

    initial begin
        reset = 1; rs1 = 0; rs2 = 0; rd = 0; id_mr = 0; br = 0; mr = 0; mw = 0; rdy = 0;
        // Reset, then idle.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        // Load-use on rs2, then the same with rd=x0, then with a taken branch.
        drive(0, 0, 5, 5, 1, 0, 0, 0, 0);
        idle(1);
        drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
        drive(0, 3, 5, 5, 1, 1, 0, 0, 0);
        idle(1);
        // Zero-wait access, then a read ready on the 4th cycle.
        drive(0, 0, 0, 0, 0, 0, 1, 0, 1);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 1);
        idle(1);
        // Never-ready write: 15 frozen cycles plus the timeout cycle.
        for (int i = 0; i < 16; i++) drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(3);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        // Reset in the middle of a wait.
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 1, 0, 0);
        idle(1);
        // 20 load-use stalls saturate the narrow counter.
        for (int i = 0; i < 20; i++) drive(0, 7, 0, 7, 1, 0, 0, 0, 0);
        idle(1);
        // Randomised traffic with sticky accesses and rare ready to reach timeouts.
        begin
            bit acc_on, acc_wr;
            acc_on = 0; acc_wr = 0;
            for (int i = 0; i < 2000; i++) begin
                bit r, ready;
                if (!acc_on && $urandom_range(0, 3) == 0) begin
                    acc_on = 1; acc_wr = 1'($urandom_range(0, 1));
                end
                ready = ($urandom_range(0, 99) < 12);
                r = ($urandom_range(0, 299) == 0);
                drive(r, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                      5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 4) == 0), acc_on && !acc_wr, acc_on && acc_wr, ready);
                if (acc_on && (ready || $urandom_range(0, 19) == 0)) acc_on = 0;
            end
        end
        idle(1);
        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
